paddle_controller_multi: RTL

//  Parametrised successor paddle position controller for N paddles driven by active-low push buttons.
//  Per paddle: two-flop button synchroniser; hold-to-accelerate speed FSM (slow step, then fast

---
 rtl/paddle_controller_multi_pkg.sv | 16 +
 rtl/paddle_controller_multi_if.sv | 25 ++
 rtl/paddle_controller_multi_axis.sv | 156 +++++++++++++++
 rtl/paddle_controller_multi.sv | 66 ++++++
 4 files changed

// File: rtl/paddle_controller_multi_pkg.sv
// Shared types and default constants for the multi-paddle position controller.
// The state encodings are fixed so that debug probes and the renderer agree on them.
package paddle_controller_multi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SLOW = 2'd1,
    ST_FAST = 2'd2
  } pad_state_e;

  localparam int DEF_SCREEN_H   = 480;
  localparam int DEF_Y_RST      = 240;
  localparam int DEF_HALF_BIG   = 50;
  localparam int DEF_HALF_SMALL = 40;

endpackage

// File: rtl/paddle_controller_multi_if.sv
// Board-side bundle for the paddle controller: raw buttons, size/freeze controls and positions.
// The master side drives the buttons; the slave side is the controller.
interface paddle_controller_multi_if #(
  parameter int N_PAD = 2,
  parameter int Y_W   = 11
);

  logic [N_PAD-1:0]     btn_up_n;
  logic [N_PAD-1:0]     btn_dn_n;
  logic [N_PAD-1:0]     bat_size;
  logic                 freeze;
  logic [N_PAD*Y_W-1:0] pos_y;
  logic [N_PAD-1:0]     moving;

  modport master (
    output btn_up_n, btn_dn_n, bat_size, freeze,
    input  pos_y, moving
  );

  modport slave (
    input  btn_up_n, btn_dn_n, bat_size, freeze,
    output pos_y, moving
  );

endinterface

// File: rtl/paddle_controller_multi_axis.sv
// One paddle channel: button synchroniser, hold-to-accelerate FSM and clamped position register.
// Movement happens only on i_tick; clamping to the bat-size dependent range happens every cycle.
module paddle_controller_multi_axis
  import paddle_controller_multi_pkg::*;
#(
  parameter int Y_W         = 11,
  parameter int SCREEN_H    = DEF_SCREEN_H,
  parameter int Y_RST       = DEF_Y_RST,
  parameter int HALF_BIG    = DEF_HALF_BIG,
  parameter int HALF_SMALL  = DEF_HALF_SMALL,
  parameter int ACCEL_TICKS = 16,
  parameter int SLOW_STEP   = 1,
  parameter int FAST_STEP   = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_tick,
  input  logic           i_btn_up_n,
  input  logic           i_btn_dn_n,
  input  logic           i_bat_size,
  output logic [Y_W-1:0] o_pos_y,
  output logic           o_moving
);

  localparam int SW     = Y_W + 1;
  localparam int HOLD_W = $clog2(ACCEL_TICKS + 1);

  logic [1:0]        r_sync_up;
  logic [1:0]        r_sync_dn;
  pad_state_e        r_state;
  pad_state_e        w_state_nxt;
  logic [HOLD_W-1:0] r_hold;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic [HOLD_W-1:0] w_hold_inc;
  logic              r_last_up;
  logic              w_last_up_nxt;
  logic              w_move;
  logic              w_fast;
  logic              w_up;
  logic              w_dn;
  logic              w_active;
  logic [Y_W-1:0]    r_pos;
  logic              r_moving;

  logic signed [SW-1:0] w_pos_s;
  logic signed [SW-1:0] w_step_s;
  logic signed [SW-1:0] w_cand;
  logic [Y_W-1:0]       w_lo;
  logic [Y_W-1:0]       w_hi;
  logic [Y_W-1:0]       w_pos_nxt;

  // Released buttons read as 1, so the synchroniser resets to the released level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_up <= 2'b11;
      r_sync_dn <= 2'b11;
    end else begin
      r_sync_up <= {r_sync_up[0], i_btn_up_n};
      r_sync_dn <= {r_sync_dn[0], i_btn_dn_n};
    end
  end

  assign w_up       = ~r_sync_up[1] & r_sync_dn[1];
  assign w_dn       = ~r_sync_dn[1] & r_sync_up[1];
  assign w_active   = w_up | w_dn;
  assign w_hold_inc = r_hold + HOLD_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_hold    <= '0;
      r_last_up <= 1'b0;
      r_pos     <= Y_W'(Y_RST);
      r_moving  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_hold    <= w_hold_nxt;
      r_last_up <= w_last_up_nxt;
      r_pos     <= w_pos_nxt;
      r_moving  <= (w_state_nxt != ST_IDLE);
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_hold_nxt    = r_hold;
    w_last_up_nxt = r_last_up;
    w_move        = 1'b0;
    w_fast        = 1'b0;
    if (i_tick) begin
      case (r_state)
        ST_IDLE: begin
          if (w_active) begin
            w_state_nxt   = ST_SLOW;
            w_hold_nxt    = HOLD_W'(1);
            w_last_up_nxt = w_up;
            w_move        = 1'b1;
          end
        end
        ST_SLOW: begin
          if (!w_active) begin
            w_state_nxt = ST_IDLE;
          end else if (w_up != r_last_up) begin
            w_hold_nxt    = HOLD_W'(1);
            w_last_up_nxt = w_up;
            w_move        = 1'b1;
          end else begin
            w_hold_nxt = w_hold_inc;
            w_move     = 1'b1;
            if (w_hold_inc == HOLD_W'(ACCEL_TICKS)) begin
              w_state_nxt = ST_FAST;
              w_fast      = 1'b1;
            end
          end
        end
        ST_FAST: begin
          if (!w_active) begin
            w_state_nxt = ST_IDLE;
          end else if (w_up != r_last_up) begin
            w_state_nxt   = ST_SLOW;
            w_hold_nxt    = HOLD_W'(1);
            w_last_up_nxt = w_up;
            w_move        = 1'b1;
          end else begin
            w_move = 1'b1;
            w_fast = 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // One extra sign bit lets a step below zero be caught by the lower clamp instead of wrapping.
  always_comb begin
    w_pos_s  = signed'({1'b0, r_pos});
    w_step_s = w_fast ? SW'(FAST_STEP) : SW'(SLOW_STEP);
    w_cand   = w_pos_s;
    if (w_move) begin
      w_cand = w_up ? (w_pos_s + w_step_s) : (w_pos_s - w_step_s);
    end
    w_lo = i_bat_size ? Y_W'(HALF_SMALL) : Y_W'(HALF_BIG);
    w_hi = Y_W'(SCREEN_H) - w_lo;
    if (w_cand < signed'({1'b0, w_lo})) begin
      w_pos_nxt = w_lo;
    end else if (w_cand > signed'({1'b0, w_hi})) begin
      w_pos_nxt = w_hi;
    end else begin
      w_pos_nxt = w_cand[Y_W-1:0];
    end
  end

  assign o_pos_y  = r_pos;
  assign o_moving = r_moving;

endmodule

// File: rtl/paddle_controller_multi.sv
// N-paddle position controller: one shared movement tick divider feeding N independent axes.
// The divider keeps counting through freeze so resumption lines up with the normal tick grid.
module paddle_controller_multi
  import paddle_controller_multi_pkg::*;
#(
  parameter int N_PAD       = 2,
  parameter int Y_W         = 11,
  parameter int SCREEN_H    = DEF_SCREEN_H,
  parameter int Y_RST       = DEF_Y_RST,
  parameter int HALF_BIG    = DEF_HALF_BIG,
  parameter int HALF_SMALL  = DEF_HALF_SMALL,
  parameter int TICK_DIV    = 2**17,
  parameter int ACCEL_TICKS = 16,
  parameter int SLOW_STEP   = 1,
  parameter int FAST_STEP   = 4
) (
  input logic                       clk,
  input logic                       rst,
  paddle_controller_multi_if.slave  io_pad
);

  localparam int CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0]     r_tick_cnt;
  logic                 w_tick;
  logic [N_PAD*Y_W-1:0] w_pos_flat;
  logic [N_PAD-1:0]     w_moving;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick_cnt <= '0;
    end else if (r_tick_cnt == CNT_W'(TICK_DIV - 1)) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + CNT_W'(1);
    end
  end

  assign w_tick = (r_tick_cnt == CNT_W'(TICK_DIV - 1)) && !io_pad.freeze;

  for (genvar g = 0; g < N_PAD; g++) begin : g_axis
    paddle_controller_multi_axis #(
      .Y_W        (Y_W),
      .SCREEN_H   (SCREEN_H),
      .Y_RST      (Y_RST),
      .HALF_BIG   (HALF_BIG),
      .HALF_SMALL (HALF_SMALL),
      .ACCEL_TICKS(ACCEL_TICKS),
      .SLOW_STEP  (SLOW_STEP),
      .FAST_STEP  (FAST_STEP)
    ) u_axis (
      .clk       (clk),
      .rst       (rst),
      .i_tick    (w_tick),
      .i_btn_up_n(io_pad.btn_up_n[g]),
      .i_btn_dn_n(io_pad.btn_dn_n[g]),
      .i_bat_size(io_pad.bat_size[g]),
      .o_pos_y   (w_pos_flat[g*Y_W +: Y_W]),
      .o_moving  (w_moving[g])
    );
  end

  assign io_pad.pos_y  = w_pos_flat;
  assign io_pad.moving = w_moving;

endmodule
